serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition; it is sampled only while busy is low.
REQ-005 The block SHALL have port augend, input, WIDTH bits: first operand, captured on an accepted start.
REQ-006 The block SHALL have port addend, input, WIDTH bits: second operand, captured on an accepted start.
REQ-007 The block SHALL have port carry_in, input, 1 bit: initial carry, captured on an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result of augend+addend+carry_in, modulo 2^WIDTH.
REQ-011 The block SHALL have port carry_out, output, 1 bit: final carry, bit WIDTH of the full result.

Function
REQ-012 The block SHALL implement a 3-state FSM with states IDLE, SHIFT and DONE.
REQ-013 In IDLE or DONE, start=1 at an edge SHALL capture augend, addend and carry_in, clear the bit counter, and move the FSM to SHIFT.
REQ-014 In SHIFT, each edge SHALL add the operand LSBs and the carry register using one full-adder bit, shift the sum bit into sum at its MSB end, shift both operands right, update the carry register, and increment the counter.
REQ-015 On the edge that processes bit WIDTH-1 the FSM SHALL move to DONE, so done is high during the cycle that follows the WIDTH-th edge after the start edge.
REQ-016 In DONE with start=0 the FSM SHALL return to IDLE on the next edge, keeping done high for exactly one cycle.
REQ-017 busy SHALL be 1 exactly when the state is SHIFT.
REQ-018 start SHALL be ignored while busy=1, and operand inputs SHALL have no effect while busy=1.
REQ-019 start=1 in DONE SHALL begin a new operation, giving back-to-back throughput of one result per WIDTH+1 cycles.
REQ-020 sum and carry_out SHALL hold their final values from DONE until the first SHIFT edge of the next operation.
REQ-021 sum and carry_out SHALL be undefined-in-content during SHIFT, and the bench SHALL NOT check them then.
REQ-022 The counter SHALL be $clog2(WIDTH) bits wide; the terminal count is WIDTH-1, with no wrap beyond it.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, sum=0, carry_out=0, counter=0, and the operand and carry registers to 0.
REQ-024 rst SHALL take priority over start at the same edge.
REQ-025 rst during SHIFT SHALL abort the operation with no done pulse.

Structure
REQ-026 A shared package serial_adder_pkg SHALL hold the FSM state enum type and the default WIDTH constant.
REQ-027 The per-bit logic SHALL be a combinational sub-module full_adder with inputs a, b, cin and outputs s, cout, instantiated once.
REQ-028 All registers SHALL be in a single always_ff block on clk.
REQ-029 No combinational path SHALL run from inputs to outputs.

Verification
REQ-030 Case 1: WIDTH=8; augend=0x00, addend=0x00, carry_in=0, start for 1 cycle -> busy high for 8 cycles, then done for 1 cycle with sum=0x00, carry_out=0.
REQ-031 Case 2: augend=0xFF, addend=0x01, carry_in=0 -> sum=0x00, carry_out=1.
REQ-032 Case 3: augend=0xA5, addend=0x5A, carry_in=1 -> sum=0x00, carry_out=1; then 0x3C+0x42, carry_in=0 started in the DONE cycle -> sum=0x7E, carry_out=0, done exactly 9 cycles after the first done.
REQ-033 Case 4: start=1 with operands 0x11+0x22 held during SHIFT of 0x01+0x01 -> result is 0x02, carry_out=0, and no extra operation is started.
REQ-034 Case 5: rst=1 on the 4th SHIFT cycle -> the next cycle shows busy=0, done=0, sum=0, carry_out=0, and no done pulse follows; rst and start together -> IDLE.
REQ-035 Case 6: exhaustive check of all 8 combinations of the full_adder inputs -> s=a^b^cin and cout=majority(a,b,cin).

Source files
------------

// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit combinational full adder used by the serial adder datapath.
// Ports:
//   a, b  - operand bits
//   cin   - carry in
//   s     - sum bit      (a ^ b ^ cin)
//   cout  - carry out    (majority of a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: computes augend + addend + carry_in over WIDTH clock
// cycles using a single full-adder bit, LSB first.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   start      - begin an addition (sampled only while busy is low)
//   augend     - first operand  (captured on accepted start)
//   addend     - second operand (captured on accepted start)
//   carry_in   - initial carry  (captured on accepted start)
//   busy       - high while bits are being processed
//   done       - one-cycle pulse: sum/carry_out valid
//   sum        - result modulo 2^WIDTH
//   carry_out  - bit WIDTH of the full result
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] augend,
    input  logic [WIDTH-1:0] addend,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   a_q,     a_d;
    logic [WIDTH-1:0]   b_q,     b_d;
    logic               c_q,     c_d;
    logic [WIDTH-1:0]   sum_q,   sum_d;
    logic               cout_q,  cout_d;

    logic fa_s;
    logic fa_cout;

    full_adder u_full_adder (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned
        // (an unassigned path would infer a latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // sum/carry_out are left alone here so the previous
                    // result stays visible until the first shift edge.
                    a_d     = augend;
                    b_d     = addend;
                    c_d     = carry_in;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Sum bits enter at the MSB end; after WIDTH shifts the LSB
                // produced first has walked down to bit 0.
                sum_d  = {fa_s, sum_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                c_d    = fa_cout;
                cout_d = fa_cout;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Operand and carry registers are cleared too so an aborted
            // operation leaves no residue visible anywhere.
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // All outputs decode registered state only: no input-to-output path.
    assign busy      = (state_q == ST_SHIFT);
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed self-checking bench for serial_adder (WIDTH=8) and full_adder.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] augend;
    logic [W-1:0] addend;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;

    logic fa_a, fa_b, fa_cin, fa_s, fa_cout;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .augend    (augend),
        .addend    (addend),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    full_adder u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (fa_cin),
        .s    (fa_s),
        .cout (fa_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start high for one edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        augend   = a;
        addend   = b;
        carry_in = ci;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Count edges until done is seen (bounded); busy cycles counted alongside.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
    endtask

    int edges, bcyc, pulses;
    logic ea, eb, ec;

    initial begin
        rst = 1'b1; start = 1'b0; augend = '0; addend = '0; carry_in = 1'b0;
        fa_a = 1'b0; fa_b = 1'b0; fa_cin = 1'b0;
        tick(); tick();

        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum",  sum, 0);
        check("reset_cout", carry_out, 0);
        rst = 1'b0;
        tick();

        // Case 1: 0x00 + 0x00 + 0
        start_op(8'h00, 8'h00, 1'b0);
        check("c1_busy_after_start", busy, 1);
        wait_done(edges, bcyc);
        check("c1_latency", edges, 8);
        check("c1_busy_cycles", bcyc, 8);
        check("c1_done", done, 1);
        check("c1_busy_in_done", busy, 0);
        check("c1_sum", sum, 8'h00);
        check("c1_cout", carry_out, 0);
        tick();
        check("c1_done_one_cycle", done, 0);

        // Case 2: 0xFF + 0x01 + 0
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(edges, bcyc);
        check("c2_latency", edges, 8);
        check("c2_sum", sum, 8'h00);
        check("c2_cout", carry_out, 1);
        tick();
        check("c2_idle_hold_sum", sum, 8'h00);
        check("c2_idle_hold_cout", carry_out, 1);

        // Case 3: 0xA5 + 0x5A + 1, then back-to-back 0x3C + 0x42 + 0
        start_op(8'hA5, 8'h5A, 1'b1);
        wait_done(edges, bcyc);
        check("c3a_done", done, 1);
        check("c3a_sum", sum, 8'h00);
        check("c3a_cout", carry_out, 1);
        start_op(8'h3C, 8'h42, 1'b0);
        check("c3b_busy_after_start", busy, 1);
        check("c3b_done_low", done, 0);
        check("c3b_sum_held", sum, 8'h00);
        check("c3b_cout_held", carry_out, 1);
        wait_done(edges, bcyc);
        check("c3b_spacing", edges + 1, 9);
        check("c3b_sum", sum, 8'h7E);
        check("c3b_cout", carry_out, 0);
        tick();

        // Case 4: start/operands toggling during SHIFT are ignored
        start_op(8'h01, 8'h01, 1'b0);
        start = 1'b1; augend = 8'h11; addend = 8'h22; carry_in = 1'b1;
        wait_done(edges, bcyc);
        check("c4_latency", edges, 8);
        check("c4_sum", sum, 8'h02);
        check("c4_cout", carry_out, 0);
        start = 1'b0;
        tick();
        check("c4_no_restart_busy", busy, 0);
        check("c4_no_restart_done", done, 0);
        tick();
        check("c4_still_idle", busy, 0);
        check("c4_sum_held", sum, 8'h02);

        // Case 5: reset on the 4th SHIFT cycle aborts
        start_op(8'hFF, 8'hFF, 1'b1);
        tick(); tick(); tick();
        check("c5_busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("c5_busy", busy, 0);
        check("c5_done", done, 0);
        check("c5_sum", sum, 0);
        check("c5_cout", carry_out, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        check("c5_no_done_after_abort", pulses, 0);

        // rst and start at the same edge: reset wins
        augend = 8'h12; addend = 8'h34; carry_in = 1'b0;
        start = 1'b1; rst = 1'b1;
        tick();
        start = 1'b0; rst = 1'b0;
        check("c5_rst_prio_busy", busy, 0);
        check("c5_rst_prio_done", done, 0);
        tick();
        check("c5_rst_prio_idle", busy, 0);

        // Case 6: full_adder truth table
        for (int v = 0; v < 8; v++) begin
            ea = v[2]; eb = v[1]; ec = v[0];
            fa_a = ea; fa_b = eb; fa_cin = ec;
            #1;
            check($sformatf("c6_s_%0d", v), fa_s, ea ^ eb ^ ec);
            check($sformatf("c6_cout_%0d", v), fa_cout, (ea & eb) | (ea & ec) | (eb & ec));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_adder
